// File: rtl/ccff_ctrl_pkg.sv
// Shared types and constants for the ccff chain loader.
// Holds the sequencer state encoding and a constant-evaluable clog2.
package ccff_ctrl_pkg;

    localparam int DEF_CHAIN_LEN = 6;
    localparam int DEF_WORD_W    = 8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        VERIFY,
        DONE
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Configuration-word handshake from the bitstream source into the chain loader.
// A word moves on any cycle with cfg_valid && cfg_ready.
interface ccff_chain_loader_if
    import ccff_ctrl_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
);
    logic              cfg_valid;
    logic [WORD_W-1:0] cfg_data;
    logic              cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_data,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_data,
        output cfg_ready
    );
endinterface

// File: rtl/ccff_word_serializer.sv
// Holds one configuration word and presents it LSB first as a registered bit.
// Load and advance take effect on the next prog_clk edge; no backpressure of its own.
module ccff_word_serializer
    import ccff_ctrl_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              i_load,
    input  logic [WORD_W-1:0] i_word,
    input  logic              i_advance,
    output logic              o_bit,
    output logic              o_last_bit
);
    localparam int IDX_W = (WORD_W > 1) ? clog2(WORD_W) : 1;

    logic [WORD_W-1:0] r_word;
    logic [IDX_W-1:0]  r_idx;
    logic              r_bit;
    logic [IDX_W-1:0]  w_idx_nxt;
    logic              w_last;

    assign w_last    = (r_idx == IDX_W'(WORD_W - 1));
    assign w_idx_nxt = r_idx + 1'b1;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_word <= '0;
            r_idx  <= '0;
            r_bit  <= 1'b0;
        end else if (i_load) begin
            r_word <= i_word;
            r_idx  <= '0;
            r_bit  <= i_word[0];
        end else if (i_advance && !w_last) begin
            // Stepping past the last bit is left to the next load.
            r_idx  <= w_idx_nxt;
            r_bit  <= r_word[w_idx_nxt];
        end
    end

    assign o_bit      = r_bit;
    assign o_last_bit = w_last;

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a tile's ccff chain from handshaked words, then recirculates it once to verify.
// One bit per enabled prog_clk; FETCH stalls hold the chain still, so stalls are lossless.
module ccff_chain_loader
    import ccff_ctrl_pkg::*;
#(
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CNT_W     = clog2(CHAIN_LEN + 1)
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic                 start,
    ccff_chain_loader_if.slave   cfg,
    output logic                 ccff_head,
    output logic                 ccff_shift_en,
    input  logic                 ccff_tail,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [CNT_W-1:0]     bit_cnt
);
    localparam int SH_W = (CHAIN_LEN > 1) ? clog2(CHAIN_LEN) : 1;

    state_t               r_state;
    logic                 r_cfg_ready;
    logic                 r_shift_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_error;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [CHAIN_LEN-1:0] r_shadow;

    logic                 w_hs;
    logic                 w_bit;
    logic                 w_last_bit;
    logic                 w_last_cnt;
    logic [SH_W-1:0]      w_sh_idx;
    logic [CNT_W-1:0]     w_cnt_inc;

    assign w_hs       = cfg.cfg_valid && r_cfg_ready;
    assign w_last_cnt = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
    assign w_sh_idx   = r_bit_cnt[SH_W-1:0];
    assign w_cnt_inc  = (r_bit_cnt == CNT_W'(CHAIN_LEN)) ? r_bit_cnt : r_bit_cnt + 1'b1;

    ccff_word_serializer #(
        .WORD_W (WORD_W)
    ) u_ser (
        .prog_clk   (prog_clk),
        .pReset     (pReset),
        .i_load     (w_hs),
        .i_word     (cfg.cfg_data),
        .i_advance  (r_state == LOAD),
        .o_bit      (w_bit),
        .o_last_bit (w_last_bit)
    );

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            r_state     <= IDLE;
            r_cfg_ready <= 1'b0;
            r_shift_en  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_bit_cnt   <= '0;
            r_shadow    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= FETCH;
                        r_cfg_ready <= 1'b1;
                        r_error     <= 1'b0;
                        r_bit_cnt   <= '0;
                        r_shadow    <= '0;
                    end
                end
                FETCH: begin
                    if (cfg.cfg_valid) begin
                        r_state     <= LOAD;
                        r_cfg_ready <= 1'b0;
                        r_shift_en  <= 1'b1;
                        r_busy      <= 1'b1;
                    end
                end
                LOAD: begin
                    r_shadow[w_sh_idx] <= w_bit;
                    if (w_last_cnt) begin
                        // Chain full: any bits left in this word are dropped.
                        r_state   <= VERIFY;
                        r_bit_cnt <= '0;
                    end else begin
                        r_bit_cnt <= w_cnt_inc;
                        if (w_last_bit) begin
                            r_state     <= FETCH;
                            r_cfg_ready <= 1'b1;
                            r_shift_en  <= 1'b0;
                            r_busy      <= 1'b0;
                        end
                    end
                end
                VERIFY: begin
                    if (ccff_tail != r_shadow[w_sh_idx]) begin
                        r_error <= 1'b1;
                    end
                    r_bit_cnt <= w_cnt_inc;
                    if (w_last_cnt) begin
                        r_state    <= DONE;
                        r_shift_en <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // During readback the tail feeds straight back so the chain ends unchanged.
    assign ccff_head     = (r_state == VERIFY) ? ccff_tail : w_bit;
    assign ccff_shift_en = r_shift_en;
    assign cfg.cfg_ready = r_cfg_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign bit_cnt       = r_bit_cnt;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Drives a 6-bit and a 20-bit chain loader against behavioural chain models.
module tb_ccff_chain_loader;

    logic       prog_clk;
    logic       pReset;
    logic       start_s[2];
    logic       cfg_valid_s[2];
    logic [7:0] cfg_data_s[2];
    logic       tail_s[2];
    logic       head_s[2];
    logic       sen_s[2];
    logic       busy_s[2];
    logic       done_s[2];
    logic       err_s[2];
    logic [2:0] bc0;
    logic [4:0] bc1;
    logic       fault_s[2];

    logic [31:0] chain_m[2];
    int          shifts_m[2];

    int checks;
    int errors;

    ccff_chain_loader_if #(.WORD_W(8)) if0 ();
    ccff_chain_loader_if #(.WORD_W(8)) if1 ();

    assign if0.cfg_valid = cfg_valid_s[0];
    assign if0.cfg_data  = cfg_data_s[0];
    assign if1.cfg_valid = cfg_valid_s[1];
    assign if1.cfg_data  = cfg_data_s[1];

    ccff_chain_loader #(.CHAIN_LEN(6), .WORD_W(8)) u_dut0 (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start_s[0]),
        .cfg           (if0),
        .ccff_head     (head_s[0]),
        .ccff_shift_en (sen_s[0]),
        .ccff_tail     (tail_s[0]),
        .busy          (busy_s[0]),
        .done          (done_s[0]),
        .error         (err_s[0]),
        .bit_cnt       (bc0)
    );

    ccff_chain_loader #(.CHAIN_LEN(20), .WORD_W(8)) u_dut1 (
        .prog_clk      (prog_clk),
        .pReset        (pReset),
        .start         (start_s[1]),
        .cfg           (if1),
        .ccff_head     (head_s[1]),
        .ccff_shift_en (sen_s[1]),
        .ccff_tail     (tail_s[1]),
        .busy          (busy_s[1]),
        .done          (done_s[1]),
        .error         (err_s[1]),
        .bit_cnt       (bc1)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: head enters bit 0, the tail is bit LEN-1.
    always @(posedge prog_clk) begin
        if (sen_s[0]) begin
            chain_m[0]  <= {chain_m[0][30:0], head_s[0]};
            shifts_m[0] <= shifts_m[0] + 1;
        end
        if (sen_s[1]) begin
            chain_m[1]  <= {chain_m[1][30:0], head_s[1]};
            shifts_m[1] <= shifts_m[1] + 1;
        end
    end

    assign tail_s[0] = fault_s[0] ? 1'b0 : chain_m[0][5];
    assign tail_s[1] = fault_s[1] ? 1'b0 : chain_m[1][19];

    function automatic int g_rdy(input int u);
        return (u == 0) ? int'(if0.cfg_ready) : int'(if1.cfg_ready);
    endfunction

    function automatic int g_cnt(input int u);
        return (u == 0) ? int'(bc0) : int'(bc1);
    endfunction

    // Loaded bit i sits i places in from the tail.
    function automatic int get_bits(input int u, input int len);
        int r;
        r = 0;
        for (int i = 0; i < len; i++) begin
            if (chain_m[u][len-1-i]) r = r | (1 << i);
        end
        return r;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_reset(input int u);
        chk("rst_rdy",  g_rdy(u),         0);
        chk("rst_head", int'(head_s[u]),  0);
        chk("rst_sen",  int'(sen_s[u]),   0);
        chk("rst_busy", int'(busy_s[u]),  0);
        chk("rst_done", int'(done_s[u]),  0);
        chk("rst_err",  int'(err_s[u]),   0);
        chk("rst_cnt",  g_cnt(u),         0);
    endtask

    task automatic run_seq(input int u, input logic [7:0] w0, input logic [7:0] w1,
                           input logic [7:0] w2, input int stall, input bit fault,
                           input bit poke, input logic [19:0] exp_bits,
                           input int exp_hs, input bit exp_err);
        int         len;
        int         base;
        int         hs;
        int         cyc;
        int         stall_left;
        int         extra;
        bit         seen;
        bit         hs_now;
        logic [7:0] words[3];
        len        = (u == 0) ? 6 : 20;
        hs         = 0;
        cyc        = 0;
        seen       = 1'b0;
        stall_left = stall;
        words[0]   = w0;
        words[1]   = w1;
        words[2]   = w2;
        fault_s[u] = fault;
        @(negedge prog_clk);
        base       = shifts_m[u];
        start_s[u] = 1'b1;
        @(negedge prog_clk);
        start_s[u] = 1'b0;
        chk("fetch_rdy",     g_rdy(u),        1);
        chk("start_err_clr", int'(err_s[u]),  0);
        chk("start_cnt",     g_cnt(u),        0);
        while (!seen && cyc < 400) begin
            if (g_rdy(u) == 1 && stall_left > 0) begin
                chk("stall_sen", int'(sen_s[u]), 0);
                stall_left--;
                cfg_valid_s[u] = 1'b0;
            end else begin
                cfg_valid_s[u] = (g_rdy(u) == 1);
                cfg_data_s[u]  = words[(hs > 2) ? 2 : hs];
            end
            hs_now     = (g_rdy(u) == 1) && cfg_valid_s[u];
            start_s[u] = poke && (shifts_m[u] - base == len + 2);
            @(negedge prog_clk);
            cyc++;
            if (hs_now) hs++;
            if (fault && (shifts_m[u] - base == len + 1))
                chk("err_first_cmp", int'(err_s[u]), 1);
            if (done_s[u]) seen = 1'b1;
        end
        cfg_valid_s[u] = 1'b0;
        start_s[u]     = 1'b0;
        chk("done_seen",  int'(seen),            1);
        chk("shift_tot",  shifts_m[u] - base,    2 * len);
        chk("handshakes", hs,                    exp_hs);
        chk("err_final",  int'(err_s[u]),        int'(exp_err));
        chk("cnt_sat",    g_cnt(u),              len);
        chk("done_sen",   int'(sen_s[u]),        0);
        if (!fault) chk("chain", get_bits(u, len), int'(exp_bits));
        start_s[u] = poke;
        @(negedge prog_clk);
        start_s[u] = 1'b0;
        chk("done_pulse", int'(done_s[u]), 0);
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge prog_clk);
            if (done_s[u]) extra++;
        end
        chk("single_done", extra,          0);
        chk("idle_rdy",    g_rdy(u),       0);
        chk("err_sticky",  int'(err_s[u]), int'(exp_err));
    endtask

    typedef struct {
        int         u;
        logic [7:0] w0;
        logic [7:0] w1;
        logic [7:0] w2;
        int         stall;
        bit         fault;
        bit         poke;
        logic [19:0] exp_bits;
        int         exp_hs;
        bit         exp_err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int          base;
        int          cyc;
        int          extra;
        int          u;
        int          len;
        logic [7:0]  a, b, c;
        logic [23:0] all;
        logic [19:0] mask;
        prog_clk = 1'b0;
        pReset   = 1'b1;
        checks   = 0;
        errors   = 0;
        for (int i = 0; i < 2; i++) begin
            start_s[i]     = 1'b0;
            cfg_valid_s[i] = 1'b0;
            cfg_data_s[i]  = 8'h00;
            fault_s[i]     = 1'b0;
        end

        tbl[0] = '{0, 8'h2D, 8'h00, 8'h00, 0, 1'b0, 1'b0, 20'h0002D, 1, 1'b0};
        tbl[1] = '{0, 8'h2D, 8'h00, 8'h00, 5, 1'b0, 1'b0, 20'h0002D, 1, 1'b0};
        tbl[2] = '{1, 8'hA5, 8'h3C, 8'hFF, 0, 1'b0, 1'b0, 20'hF3CA5, 3, 1'b0};
        tbl[3] = '{0, 8'h3F, 8'h00, 8'h00, 0, 1'b1, 1'b0, 20'h0003F, 1, 1'b1};
        tbl[4] = '{0, 8'hD2, 8'h00, 8'h00, 2, 1'b0, 1'b0, 20'h00012, 1, 1'b0};
        tbl[5] = '{0, 8'h2D, 8'h00, 8'h00, 0, 1'b0, 1'b1, 20'h0002D, 1, 1'b0};

        repeat (3) @(negedge prog_clk);
        chk_reset(0);
        chk_reset(1);
        pReset = 1'b0;

        for (int k = 0; k < 6; k++) begin
            run_seq(tbl[k].u, tbl[k].w0, tbl[k].w1, tbl[k].w2, tbl[k].stall,
                    tbl[k].fault, tbl[k].poke, tbl[k].exp_bits, tbl[k].exp_hs,
                    tbl[k].exp_err);
        end

        // Abort in the middle of LOAD.
        @(negedge prog_clk);
        start_s[0] = 1'b1;
        @(negedge prog_clk);
        start_s[0]     = 1'b0;
        cfg_valid_s[0] = 1'b1;
        cfg_data_s[0]  = 8'h2D;
        base = shifts_m[0];
        cyc  = 0;
        while (shifts_m[0] - base < 3 && cyc < 50) begin
            @(negedge prog_clk);
            cyc++;
            if (g_rdy(0) == 0) cfg_valid_s[0] = 1'b0;
        end
        cfg_valid_s[0] = 1'b0;
        chk("abort_reach", shifts_m[0] - base, 3);
        pReset = 1'b1;
        @(negedge prog_clk);
        pReset = 1'b0;
        chk_reset(0);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge prog_clk);
            if (done_s[0]) extra++;
        end
        chk("abort_no_done", extra, 0);
        run_seq(0, 8'h2D, 8'h00, 8'h00, 0, 1'b0, 1'b0, 20'h0002D, 1, 1'b0);

        for (int k = 0; k < 6; k++) begin
            u    = int'($urandom_range(0, 1));
            len  = (u == 0) ? 6 : 20;
            a    = 8'($urandom);
            b    = 8'($urandom);
            c    = 8'($urandom);
            all  = {c, b, a};
            mask = 20'((1 << len) - 1);
            run_seq(u, a, b, c, int'($urandom_range(0, 3)), 1'b0, 1'b0,
                    all[19:0] & mask, (len + 7) / 8, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired before the summary");
        $fatal(1);
    end

endmodule
